// File: rtl/sram_2rw_param.sv
// Single-clock dual-port (2RW) SRAM with auto-clear after reset, 1/2-cycle read latency
// and defined same-address read/write and write/write behaviour.
//
// state    | meaning
// ST_CLEAR | zeroing one word per cycle from address 0; ports ignored
// ST_READY | normal operation until the next reset
module sram_2rw_param #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [DATA_W-1:0] I1,
  input  logic [DATA_W-1:0] I2,
  input  logic              CSB1,
  input  logic              CSB2,
  input  logic              OEB1,
  input  logic              OEB2,
  input  logic              WEB1,
  input  logic              WEB2,
  output logic [DATA_W-1:0] O1,
  output logic [DATA_W-1:0] O2,
  output logic              V1,
  output logic              V2,
  output logic              init_busy,
  output logic              coll
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic ready;
  logic re1, re2, we1, we2, same_wr;
  logic [DATA_W-1:0] rd1, rd2;

  assign ready   = (state == ST_READY);
  assign re1     = ready & ~CSB1 & ~OEB1;
  assign re2     = ready & ~CSB2 & ~OEB2;
  assign we1     = ready & ~CSB1 & ~WEB1;
  assign we2     = ready & ~CSB2 & ~WEB2;
  assign same_wr = we1 & we2 & (A1 == A2);

  // Write-through bypass; port 1 data is assigned last so it wins a double write.
  always_comb begin
    rd1 = mem[A1];
    rd2 = mem[A2];
    if (WR_MODE != 0) begin
      if (we2 && (A2 == A1)) rd1 = I2;
      if (we1)               rd1 = I1;
      if (we2)               rd2 = I2;
      if (we1 && (A1 == A2)) rd2 = I1;
    end
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (we2 && !same_wr) mem[A2] <= I2;
      if (we1)             mem[A1] <= I1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
      coll      <= 1'b0;
    end else begin
      coll <= same_wr;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_READY;
            init_busy <= 1'b0;
          end
        end
        ST_READY: state <= ST_READY;
        default:  state <= ST_CLEAR;
      endcase
    end
  end

  // Feed for the output register: direct for RD_LAT=1, one extra stage for RD_LAT=2.
  logic              p_v1, p_v2;
  logic [DATA_W-1:0] p_d1, p_d2;

  generate
    if (RD_LAT == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_v1 <= 1'b0;
          p_v2 <= 1'b0;
          p_d1 <= '0;
          p_d2 <= '0;
        end else begin
          p_v1 <= re1;
          p_v2 <= re2;
          if (re1) p_d1 <= rd1;
          if (re2) p_d2 <= rd2;
        end
      end
    end else begin : g_lat1
      assign p_v1 = re1;
      assign p_v2 = re2;
      assign p_d1 = rd1;
      assign p_d2 = rd2;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O1 <= '0;
      O2 <= '0;
      V1 <= 1'b0;
      V2 <= 1'b0;
    end else begin
      V1 <= p_v1;
      V2 <= p_v2;
      if (p_v1) O1 <= p_d1;
      if (p_v2) O2 <= p_d2;
    end
  end

endmodule

// File: tb/tb_sram_2rw_param.sv
// Bench for sram_2rw_param: two instances (RD_LAT=1/read-first, RD_LAT=2/write-through)
// share stimulus; a reference memory feeds a scoreboard of expected read returns.
module tb_sram_2rw_param;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] a1, a2;
  logic [DW-1:0] i1, i2;
  logic csb1, csb2, oeb1, oeb2, web1, web2;

  logic [DW-1:0] o_a1, o_a2, o_b1, o_b2;
  logic v_a1, v_a2, v_b1, v_b2;
  logic busy_a, busy_b, coll_a, coll_b;

  sram_2rw_param #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1), .WR_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .A1(a1), .A2(a2), .I1(i1), .I2(i2),
    .CSB1(csb1), .CSB2(csb2), .OEB1(oeb1), .OEB2(oeb2), .WEB1(web1), .WEB2(web2),
    .O1(o_a1), .O2(o_a2), .V1(v_a1), .V2(v_a2), .init_busy(busy_a), .coll(coll_a));

  sram_2rw_param #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(2), .WR_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .A1(a1), .A2(a2), .I1(i1), .I2(i2),
    .CSB1(csb1), .CSB2(csb2), .OEB1(oeb1), .OEB2(oeb2), .WEB1(web1), .WEB2(web2),
    .O1(o_b1), .O2(o_b2), .V1(v_b1), .V2(v_b2), .init_busy(busy_b), .coll(coll_b));

  // ch 0/1 = dut_a port 1/2, ch 2/3 = dut_b port 1/2
  typedef struct {
    int            ch;
    int            due;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last_o [4];
  int clr_left = DEPTH;
  int cyc      = 0;
  int n_vec    = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle();
    csb1 = 1; oeb1 = 1; web1 = 1; a1 = '0; i1 = '0;
    csb2 = 1; oeb2 = 1; web2 = 1; a2 = '0; i2 = '0;
  endtask

  task automatic set_p1(input bit rd, input bit wr, input int a, input logic [DW-1:0] d);
    csb1 = !(rd || wr); oeb1 = !rd; web1 = !wr; a1 = AW'(a); i1 = d;
  endtask

  task automatic set_p2(input bit rd, input bit wr, input int a, input logic [DW-1:0] d);
    csb2 = !(rd || wr); oeb2 = !rd; web2 = !wr; a2 = AW'(a); i2 = d;
  endtask

  function automatic logic [DW-1:0] model_rd(input int mode, input logic [AW-1:0] a,
                                              input bit w1, input bit w2);
    if (mode == 1 && w1 && a1 == a) return i1;
    if (mode == 1 && w2 && a2 == a) return i2;
    return mem_m[a];
  endfunction

  task automatic check_outputs();
    logic [DW-1:0] o;
    logic          v;
    int            idx;
    for (int ch = 0; ch < 4; ch++) begin
      case (ch)
        0: begin o = o_a1; v = v_a1; end
        1: begin o = o_a2; v = v_a2; end
        2: begin o = o_b1; v = v_b1; end
        default: begin o = o_b2; v = v_b2; end
      endcase
      idx = -1;
      for (int k = 0; k < sb.size(); k++)
        if (idx < 0 && sb[k].ch == ch && sb[k].due == cyc) idx = k;
      if (idx >= 0) begin
        check_eq($sformatf("valid_ch%0d", ch), 32'(v), 32'(1));
        check_eq($sformatf("data_ch%0d", ch), 32'(o), 32'(sb[idx].d));
        last_o[ch] = sb[idx].d;
        sb.delete(idx);
      end else begin
        check_eq($sformatf("novalid_ch%0d", ch), 32'(v), 32'(0));
        check_eq($sformatf("hold_ch%0d", ch), 32'(o), 32'(last_o[ch]));
      end
    end
  endtask

  // One clock: predict from the driven inputs, clock, update model, check at negedge.
  task automatic step();
    bit ready, w1, w2, r1, r2, exp_coll;
    ready    = (clr_left == 0);
    w1       = ready && !csb1 && !web1;
    w2       = ready && !csb2 && !web2;
    r1       = ready && !csb1 && !oeb1;
    r2       = ready && !csb2 && !oeb2;
    exp_coll = w1 && w2 && (a1 == a2);
    if (r1) begin
      sb.push_back('{ch: 0, due: cyc + 1, d: model_rd(0, a1, w1, w2)});
      sb.push_back('{ch: 2, due: cyc + 2, d: model_rd(1, a1, w1, w2)});
    end
    if (r2) begin
      sb.push_back('{ch: 1, due: cyc + 1, d: model_rd(0, a2, w1, w2)});
      sb.push_back('{ch: 3, due: cyc + 2, d: model_rd(1, a2, w1, w2)});
    end
    @(posedge clk);
    cyc++;
    if (ready) begin
      if (w2 && !(w1 && a1 == a2)) mem_m[a2] = i2;
      if (w1) mem_m[a1] = i1;
    end else begin
      clr_left--;
    end
    @(negedge clk);
    check_eq("busy_a", 32'(busy_a), 32'(clr_left > 0));
    check_eq("busy_b", 32'(busy_b), 32'(clr_left > 0));
    check_eq("coll_a", 32'(coll_a), 32'(exp_coll));
    check_eq("coll_b", 32'(coll_b), 32'(exp_coll));
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    idle();
    for (int k = 0; k < n; k++) step();
  endtask

  // Called at a negedge; asserts reset before the next rising edge.
  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    sb.delete();
    #2;
    check_eq("rst_o_a1", 32'(o_a1), 0);
    check_eq("rst_o_a2", 32'(o_a2), 0);
    check_eq("rst_o_b1", 32'(o_b1), 0);
    check_eq("rst_o_b2", 32'(o_b2), 0);
    check_eq("rst_v", 32'({v_a1, v_a2, v_b1, v_b2}), 0);
    check_eq("rst_busy", 32'({busy_a, busy_b}), 32'(3));
    check_eq("rst_coll", 32'({coll_a, coll_b}), 0);
    for (int k = 0; k < 4; k++) last_o[k] = '0;
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
    @(negedge clk);
    rst_n    = 1'b1;
    clr_left = DEPTH;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    idle();
    while ((busy_a || busy_b) && n < 100) begin
      step();
      n++;
    end
    check_eq("busy_cycles", 32'(n), 32'(DEPTH));
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    wait_ready();

    // Preload every word with a nonzero pattern, both ports writing distinct addresses.
    for (int k = 0; k < 16; k++) begin
      set_p1(0, 1, k, DW'(16'h0101 * (k + 1)));
      set_p2(0, 1, k + 16, DW'(16'hA000 + k));
      step();
    end
    set_p1(1, 0, 3, '0); set_p2(1, 0, 20, '0); step();
    idle_steps(3);

    // Reset after preload: everything must read back zero.
    do_reset();
    wait_ready();
    for (int k = 0; k < 16; k++) begin
      set_p1(1, 0, k, '0);
      set_p2(1, 0, k + 16, '0);
      step();
    end
    idle_steps(3);

    // Latency.
    set_p1(0, 1, 5, 16'hBEEF); step();
    idle(); set_p2(1, 0, 5, '0); step();
    idle_steps(3);

    // Cross-port same address, then same-port read+write.
    set_p1(0, 1, 7, 16'h1111); step();
    set_p1(0, 1, 7, 16'h2222); set_p2(1, 0, 7, '0); step();
    idle(); set_p1(0, 1, 9, 16'h3333); step();
    set_p1(1, 1, 9, 16'h4444); step();
    idle(); set_p2(1, 0, 9, '0); step();
    idle_steps(3);

    // Write-write collision, then different-address writes.
    set_p1(0, 1, 3, 16'hAAAA); set_p2(0, 1, 3, 16'h5555); step();
    idle_steps(2);
    set_p1(1, 0, 3, '0); step();
    set_p1(0, 1, 3, 16'h1357); set_p2(0, 1, 4, 16'h2468); step();
    idle(); set_p1(1, 0, 3, '0); set_p2(1, 0, 4, '0); step();
    // Double write plus a read of the same address on port 2 via write-through.
    set_p1(0, 1, 6, 16'hCAFE); set_p2(1, 1, 6, 16'hF00D); step();
    idle(); set_p1(1, 0, 6, '0); step();
    idle_steps(3);

    // Chip select blocks the port.
    set_p1(0, 1, 10, 16'h1234); step();
    set_p1(1, 0, 10, '0); step();
    idle_steps(2);
    for (int k = 0; k < 4; k++) begin
      csb1 = 1; oeb1 = 0; web1 = 0; a1 = 10; i1 = 16'hDEAD;
      step();
    end
    set_p1(1, 0, 10, '0); step();
    idle_steps(3);

    // Randomised traffic over a small address window to provoke collisions.
    for (int k = 0; k < 300; k++) begin
      set_p1($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5), DW'($urandom));
      set_p2($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5), DW'($urandom));
      if ($urandom_range(0, 7) == 0) csb1 = 1;
      step();
    end
    idle_steps(3);
    check_eq("sb_drained", 32'(sb.size()), 0);

    // Reset mid-clear.
    do_reset();
    idle_steps(10);
    do_reset();
    wait_ready();

    // Reset with an RD_LAT=2 read in flight.
    set_p1(0, 1, 12, 16'h7777); step();
    set_p1(1, 0, 12, '0); set_p2(1, 0, 12, '0); step();
    do_reset();
    wait_ready();
    set_p1(1, 0, 12, '0); step();
    idle_steps(3);
    check_eq("sb_empty_end", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
